// File: rtl/sbp_stage_update_arbiter.sv
// Arbitrates one lookup stage's single-port memory between lookup reads and buffered update writes.
// Optional saturating write/hold statistics are enabled with `define SBP_UPD_STATS_EN.
module sbp_stage_update_arbiter #(
    parameter int unsigned STAGE_ID      = 1,
    parameter int unsigned STAGE_ID_BITS = 6,
    parameter int unsigned ADDR_BITS     = 11,
    parameter int unsigned DATA_BITS     = 64,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned MAX_WAIT      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             lookup_valid_i,
    input  logic [STAGE_ID_BITS-1:0]         lookup_stage_id_i,
    input  logic [ADDR_BITS-1:0]             lookup_addr_i,
    input  logic                             upd_valid_i,
    output logic                             upd_ready_o,
    input  logic [ADDR_BITS-1:0]             upd_addr_i,
    input  logic [DATA_BITS-1:0]             upd_data_i,
    output logic                             mem_we_o,
    output logic [ADDR_BITS-1:0]             mem_addr_o,
    output logic [DATA_BITS-1:0]             mem_wdata_o,
    output logic                             hold_o,
`ifdef SBP_UPD_STATS_EN
    output logic [31:0]                      stat_writes_o,
    output logic [31:0]                      stat_hold_cycles_o,
`endif
    output logic [$clog2(FIFO_DEPTH):0]      pending_o
);

    localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    logic [ADDR_BITS-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] data_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]  rd_ptr;
    logic [PTR_BITS-1:0]  wr_ptr;
    logic [CNT_BITS-1:0]  count;
    logic [CNT_BITS-1:0]  count_next;
    logic [7:0]           wait_cnt;
    state_t               state;

    logic busy;
    logic full;
    logic non_empty;
    logic pop;
    logic push;

    always_comb begin
        busy      = lookup_valid_i && (lookup_stage_id_i == STAGE_ID_BITS'(STAGE_ID));
        full      = (count == CNT_BITS'(FIFO_DEPTH));
        non_empty = (count != '0);
        pop       = !rst && !busy && non_empty;
        // A full FIFO still takes a new entry when the head drains in the same cycle.
        push      = !rst && upd_valid_i && (!full || pop);
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_BITS'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_BITS'(1);
        end
    end

    always_comb begin
        upd_ready_o = !rst && !full;
        mem_we_o    = pop;
        mem_addr_o  = pop ? addr_mem[rd_ptr] : lookup_addr_i;
        mem_wdata_o = data_mem[rd_ptr];
        pending_o   = count;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= upd_addr_i;
            data_mem[wr_ptr] <= upd_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
            state    <= S_IDLE;
            hold_o   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            count <= count_next;

            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    hold_o   <= 1'b0;
                    if (push) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    hold_o <= 1'b0;
                    if (pop) begin
                        wait_cnt <= '0;
                        state    <= (count_next == '0) ? S_IDLE : S_WAIT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        // Hold becomes visible in the cycle right after the limit is reached.
                        if (wait_cnt == 8'(MAX_WAIT - 1)) begin
                            state  <= S_HOLD;
                            hold_o <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (pop) begin
                        wait_cnt <= '0;
                        hold_o   <= 1'b0;
                        state    <= (count_next == '0) ? S_IDLE : S_WAIT;
                    end
                end
                default: begin
                    wait_cnt <= '0;
                    hold_o   <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SBP_UPD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_writes_o      <= '0;
            stat_hold_cycles_o <= '0;
        end else begin
            if (pop && (stat_writes_o != '1)) begin
                stat_writes_o <= stat_writes_o + 32'd1;
            end
            if (hold_o && (stat_hold_cycles_o != '1)) begin
                stat_hold_cycles_o <= stat_hold_cycles_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sbp_stage_update_arbiter.sv
// Randomized and directed checks of sbp_stage_update_arbiter against a queue-based reference model.
module tb_sbp_stage_update_arbiter;

    localparam int STAGE_ID   = 1;
    localparam int DEPTH      = 4;
    localparam int MAX_WAIT   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_valid_i;
    logic [5:0]  lookup_stage_id_i;
    logic [10:0] lookup_addr_i;
    logic        upd_valid_i;
    logic        upd_ready_o;
    logic [10:0] upd_addr_i;
    logic [63:0] upd_data_i;
    logic        mem_we_o;
    logic [10:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        hold_o;
    logic [2:0]  pending_o;
`ifdef SBP_UPD_STATS_EN
    logic [31:0] stat_writes_o;
    logic [31:0] stat_hold_cycles_o;
`endif

    sbp_stage_update_arbiter #(
        .STAGE_ID(STAGE_ID), .STAGE_ID_BITS(6), .ADDR_BITS(11), .DATA_BITS(64),
        .FIFO_DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .lookup_valid_i(lookup_valid_i), .lookup_stage_id_i(lookup_stage_id_i),
        .lookup_addr_i(lookup_addr_i),
        .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
        .upd_addr_i(upd_addr_i), .upd_data_i(upd_data_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .hold_o(hold_o),
`ifdef SBP_UPD_STATS_EN
        .stat_writes_o(stat_writes_o), .stat_hold_cycles_o(stat_hold_cycles_o),
`endif
        .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] a;
        logic [63:0] d;
    } ent_t;

    // Reference model: pending writes in acceptance order, cycles since a write was last serviced.
    ent_t        q[$];
    int          age;
    bit          m_hold;
    int unsigned m_writes;
    int unsigned m_hold_cycles;

    int checks = 0;
    int errors = 0;
    bit last_hold;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit lv, input logic [5:0] id, input logic [10:0] la,
                        input bit uv, input logic [10:0] ua, input logic [63:0] ud);
        bit   busy;
        bit   e_we;
        bit   e_push;
        bit   had_entries;
        ent_t e;
        rst = r; lookup_valid_i = lv; lookup_stage_id_i = id; lookup_addr_i = la;
        upd_valid_i = uv; upd_addr_i = ua; upd_data_i = ud;
        #2;
        busy = lv && (id == 6'(STAGE_ID));
        e_we = !r && !busy && (q.size() > 0);
        check("mem_we", 64'(mem_we_o), 64'(e_we));
        check("mem_addr", 64'(mem_addr_o), e_we ? 64'(q[0].a) : 64'(la));
        if (e_we) check("mem_wdata", mem_wdata_o, q[0].d);
        check("upd_ready", 64'(upd_ready_o), 64'(!r && (q.size() < DEPTH)));
        check("pending", 64'(pending_o), 64'(q.size()));
        check("hold", 64'(hold_o), 64'(m_hold));
`ifdef SBP_UPD_STATS_EN
        check("stat_writes", 64'(stat_writes_o), 64'(m_writes));
        check("stat_hold", 64'(stat_hold_cycles_o), 64'(m_hold_cycles));
`endif
        last_hold = hold_o;

        e_push = !r && uv && ((q.size() < DEPTH) || e_we);
        if (r) begin
            q.delete();
            age = 0; m_hold = 0; m_writes = 0; m_hold_cycles = 0;
        end else begin
            if (m_hold && m_hold_cycles != 32'hFFFF_FFFF) m_hold_cycles++;
            if (e_we && m_writes != 32'hFFFF_FFFF) m_writes++;
            had_entries = q.size() > 0;
            if (e_we) void'(q.pop_front());
            if (e_push) begin
                e.a = ua; e.d = ud;
                q.push_back(e);
            end
            if (q.size() == 0 || e_we) begin
                age = 0; m_hold = 0;
            end else if (had_entries) begin
                age++;
                if (age >= MAX_WAIT) m_hold = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 6'd0, 11'd0, 0, 11'd0, 64'd0);
    endtask

    initial begin
        int n;
        int hold_seen;
        logic [5:0] other_id;
        other_id = 6'(STAGE_ID + 1);
        rst = 1'b1; lookup_valid_i = 0; lookup_stage_id_i = '0; lookup_addr_i = '0;
        upd_valid_i = 0; upd_addr_i = '0; upd_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        q.delete(); age = 0; m_hold = 0; m_writes = 0; m_hold_cycles = 0;
        do_reset();

        // Idle drain
        step(0, 0, 6'd0, 11'h000, 1, 11'h010, 64'hDEADBEEF00000001);
        step(0, 0, 6'd0, 11'h000, 0, 11'h000, 64'd0);
        repeat (3) step(0, 0, 6'd0, 11'h000, 0, 11'h000, 64'd0);
        check("drain_pending", 64'(pending_o), 64'd0);

        // Lookup priority and hold latency
        do_reset();
        step(0, 1, 6'(STAGE_ID), 11'h123, 1, 11'h055, 64'h1111_2222_3333_4444);
        n = 0; hold_seen = 0;
        do begin
            step(0, 1, 6'(STAGE_ID), 11'h123, 0, 11'h000, 64'd0);
            n++;
        end while (!last_hold && n <= 40);
        if (last_hold) hold_seen++;
        check("hold_latency", 64'(n), 64'd17);
        step(0, 0, 6'(STAGE_ID), 11'h123, 0, 11'h000, 64'd0);
        if (last_hold) hold_seen++;
        step(0, 0, 6'(STAGE_ID), 11'h123, 0, 11'h000, 64'd0);
        check("hold_released", 64'(last_hold), 64'd0);
`ifdef SBP_UPD_STATS_EN
        check("stats_writes_once", 64'(stat_writes_o), 64'd1);
        check("stats_hold_dur", 64'(stat_hold_cycles_o), 64'(hold_seen));
`endif

        // Other-stage tokens leave the slot free
        do_reset();
        for (int i = 0; i < 3; i++)
            step(0, 1, other_id, 11'h200, 1, 11'(11'h300 + i), 64'(64'hA0 + i));
        repeat (3) step(0, 1, other_id, 11'h200, 0, 11'h000, 64'd0);

        // Full FIFO, refused offer, push-with-pop while full
        do_reset();
        for (int i = 0; i < 5; i++)
            step(0, 1, 6'(STAGE_ID), 11'h040, 1, 11'(11'h400 + i), 64'(64'hB0 + i));
        step(0, 0, 6'd0, 11'h040, 1, 11'h4AA, 64'hBEEF);
        check("full_push_pop", 64'(pending_o), 64'd4);
        repeat (6) step(0, 0, 6'd0, 11'h040, 0, 11'h000, 64'd0);

        // Reset while holding three pending writes
        do_reset();
        for (int i = 0; i < 3; i++)
            step(0, 1, 6'(STAGE_ID), 11'h050, 1, 11'(11'h500 + i), 64'(64'hC0 + i));
        n = 0;
        do begin
            step(0, 1, 6'(STAGE_ID), 11'h050, 0, 11'h000, 64'd0);
            n++;
        end while (!last_hold && n <= 40);
        check("hold_before_rst", 64'(last_hold), 64'd1);
        do_reset();
        repeat (4) step(0, 0, 6'd0, 11'h050, 0, 11'h000, 64'd0);

        // Randomized phases with increasing lookup pressure
        for (int p = 0; p < 4; p++) begin
            int busy_pct;
            busy_pct = (p == 0) ? 20 : (p == 1) ? 60 : (p == 2) ? 95 : 100;
            for (int c = 0; c < 600; c++) begin
                bit          r;
                bit          lv;
                logic [5:0]  id;
                r  = ($urandom_range(0, 299) == 0);
                lv = ($urandom_range(0, 99) < busy_pct);
                id = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(STAGE_ID);
                step(r, lv, id, 11'($urandom), $urandom_range(0, 1) == 1,
                     11'($urandom), {$urandom, $urandom});
            end
            repeat (DEPTH + 2) step(0, 0, 6'd0, 11'd0, 0, 11'd0, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
